// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit : IF stage plus IF/ID pipeline register of the RV32I pipeline.
//
// Holds the PC and fetches one word at a time from instruction memory over a
// req/ack handshake. The memory may answer in the same cycle (0-latency) or
// any number of cycles later. One extra word is buffered when decode stalls.
// A taken branch/jump from EX squashes the IF/ID slot, the buffer and any
// outstanding fetch. Invalid IF/ID slots always carry NOP_INSTR.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   stall             ID cannot accept; IF/ID contents held
//   br_taken          redirect from EX (flush)
//   br_target         redirect PC, low two bits ignored
//   imem_req/addr     fetch request, held stable until imem_ack
//   imem_rdata/ack    fetch response
//   pc_if_id          PC of the instruction in IF/ID
//   instruction       IF/ID instruction word
//   valid_if_id       IF/ID holds a live instruction
//
// Build option
//   FETCH_PERF_CNT_EN : adds perf_stall_cyc (cycles with stall & valid_if_id)
//                       and perf_flush_cnt (cycles with br_taken), 32-bit
//                       wrapping counters. Absent when undefined.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] pc_if_id,
  output logic [31:0] instruction,
`ifdef FETCH_PERF_CNT_EN
  output logic        valid_if_id,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt
`else
  output logic        valid_if_id
`endif
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;
  logic [31:0] saved_target;

  logic        accept;
  logic [31:0] target_al;
  logic        load_fetch;
  logic        load_hold;

  assign accept    = !stall || !valid_if_id;
  assign target_al = br_target & 32'hFFFF_FFFC;

  // No request in HOLD: capacity (IF/ID + buffer) is full there.
  assign imem_req  = !rst && (state != HOLD);
  assign imem_addr = pc;

  // New word enters IF/ID either straight from memory or from the buffer.
  assign load_fetch = (state == FETCH) && imem_ack && !br_taken && accept;
  assign load_hold  = (state == HOLD) && !br_taken && accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      hold_pc      <= 32'h0000_0000;
      hold_instr   <= NOP_INSTR;
      saved_target <= 32'h0000_0000;
      pc_if_id     <= 32'h0000_0000;
      instruction  <= NOP_INSTR;
      valid_if_id  <= 1'b0;
    end else begin
      // ---- IF stage: PC / request control ----
      case (state)
        FETCH: begin
          if (imem_ack) begin
            if (br_taken) begin
              pc <= target_al;
            end else begin
              pc <= pc + 32'd4;
              if (!accept) begin
                hold_pc    <= pc;
                hold_instr <= imem_rdata;
                state      <= HOLD;
              end
            end
          end else if (br_taken) begin
            // Address must stay put until the in-flight request completes.
            saved_target <= target_al;
            state        <= DISCARD;
          end
        end
        HOLD: begin
          if (br_taken) begin
            pc    <= target_al;
            state <= FETCH;
          end else if (accept) begin
            state <= FETCH;
          end
        end
        DISCARD: begin
          if (br_taken) saved_target <= target_al;
          if (imem_ack) begin
            pc    <= br_taken ? target_al : saved_target;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase

      // ---- IF/ID boundary ----
      if (br_taken) begin
        valid_if_id <= 1'b0;
        instruction <= NOP_INSTR;
      end else if (load_fetch) begin
        pc_if_id    <= pc;
        instruction <= imem_rdata;
        valid_if_id <= 1'b1;
      end else if (load_hold) begin
        pc_if_id    <= hold_pc;
        instruction <= hold_instr;
        valid_if_id <= 1'b1;
      end else if (accept) begin
        valid_if_id <= 1'b0;
        instruction <= NOP_INSTR;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cyc <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (stall && valid_if_id) perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (br_taken)             perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] pc_if_id;
  logic [31:0] instruction;
  logic        valid_if_id;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cyc;
  logic [31:0] perf_flush_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Expected program-order PCs that ID should consume, rebuilt on every redirect.
  logic [31:0] exp_q[$];

  int          lat_fixed = 0;   // <0 : random latency per request
  int unsigned wait_cnt;
  int unsigned lat;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .pc_if_id    (pc_if_id),
    .instruction (instruction),
`ifdef FETCH_PERF_CNT_EN
    .valid_if_id (valid_if_id),
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_cnt (perf_flush_cnt)
`else
    .valid_if_id (valid_if_id)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  function automatic int unsigned pick_lat();
    if (lat_fixed >= 0) return lat_fixed;
    return $urandom_range(0, 4);
  endfunction

  // Instruction memory: acks after 'lat' cycles of request (0 = same cycle).
  always_comb begin
    imem_ack   = imem_req && (wait_cnt >= lat);
    imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hBAD0_BAD0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 0;
      lat      <= pick_lat();
    end else if (imem_req && imem_ack) begin
      wait_cnt <= 0;
      lat      <= pick_lat();
    end else if (imem_req) begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic start_stream(input logic [31:0] t);
    logic [31:0] a;
    exp_q.delete();
    a = t & 32'hFFFF_FFFC;
    for (int k = 0; k < 256; k++) begin
      exp_q.push_back(a);
      a = a + 32'd4;
    end
  endtask

  task automatic wait_ack(input int max_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (!imem_ack && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (!imem_ack) begin
      n_vec++;
      n_err++;
      $display("FAIL ack_timeout: no imem_ack within %0d cycles", max_cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: consumes IF/ID whenever ID takes it, plus handshake invariants.
  logic        prev_pend;
  logic [31:0] prev_addr;
  logic [31:0] mon_e;

  always @(negedge clk) begin
    if (rst) begin
      prev_pend <= 1'b0;
    end else begin
      if (prev_pend) begin
        check("req_held", 32'(imem_req), 32'd1);
        check("addr_stable", imem_addr, prev_addr);
      end
      if (imem_req) check("addr_align", 32'(imem_addr[1:0]), 32'd0);
      if (!valid_if_id) begin
        check("nop_when_invalid", instruction, NOP);
      end else if (!stall && !br_taken) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL if_id_extra: got pc %h, expected no instruction", pc_if_id);
        end else begin
          mon_e = exp_q.pop_front();
          check("if_id_pc", pc_if_id, mon_e);
          check("if_id_instr", instruction, mem_word(mon_e));
        end
      end
      prev_pend <= imem_req && !imem_ack;
      prev_addr <= imem_addr;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] f_pc;
    logic [31:0] f_in;
    int since;

    // T1: reset values, then 0-latency fetch stream
    lat_fixed = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(valid_if_id), 32'd0);
    check("rst_instr", instruction, NOP);
    check("rst_pc_if_id", pc_if_id, 32'd0);
    tick();
    rst = 1'b0;
    start_stream(RESET_PC);
    @(negedge clk);
    check("t1_req_c1", 32'(imem_req), 32'd1);
    check("t1_addr_c1", imem_addr, 32'h0);
    check("t1_valid_c1", 32'(valid_if_id), 32'd0);
    tick();
    @(negedge clk);
    check("t1_addr_c2", imem_addr, 32'h4);
    check("t1_valid_c2", 32'(valid_if_id), 32'd1);
    tick();
    @(negedge clk);
    check("t1_addr_c3", imem_addr, 32'h8);

    // T2: 3-cycle latency, address held
    lat_fixed = 3;
    wait_ack(10);
    a = imem_addr + 32'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_addr_hold", imem_addr, a);
      check("t2_no_ack", 32'(imem_ack), 32'd0);
    end
    @(negedge clk);
    check("t2_ack", 32'(imem_ack), 32'd1);
    check("t2_ack_addr", imem_addr, a);

    // T3: 4-cycle stall with live IF/ID
    lat_fixed = 0;
    wait_ack(10);
    wait_ack(10);
    tick();
    stall = 1'b1;
    check("t3_valid_before", 32'(valid_if_id), 32'd1);
    f_pc = pc_if_id;
    f_in = instruction;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_frozen_pc", pc_if_id, f_pc);
      check("t3_frozen_instr", instruction, f_in);
      if (i > 0) check("t3_req_low", 32'(imem_req), 32'd0);
      tick();
    end
    stall = 1'b0;
    tick();
    @(negedge clk);
    check("t3_buffered_pc", pc_if_id, f_pc + 32'd4);
    check("t3_buffered_valid", 32'(valid_if_id), 32'd1);

    // T4: redirect in the ack cycle
    wait_ack(10);
    tick();
    br_taken  = 1'b1;
    br_target = 32'h0000_0103;
    start_stream(br_target);
    @(negedge clk);
    check("t4_ack_same_cycle", 32'(imem_ack), 32'd1);
    tick();
    br_taken = 1'b0;
    @(negedge clk);
    check("t4_addr", imem_addr, 32'h0000_0100);
    check("t4_instr", instruction, NOP);
    check("t4_valid", 32'(valid_if_id), 32'd0);

    // T5: two redirects while a request is pending
    lat_fixed = 5;
    wait_ack(10);
    tick();
    a = imem_addr;
    br_taken  = 1'b1;
    br_target = 32'h0000_0200;
    start_stream(br_target);
    @(negedge clk);
    check("t5_pending", 32'(imem_ack), 32'd0);
    tick();
    br_target = 32'h0000_0300;
    start_stream(br_target);
    @(negedge clk);
    check("t5_addr_kept", imem_addr, a);
    tick();
    br_taken = 1'b0;
    wait_ack(20);
    check("t5_dropped", 32'(valid_if_id), 32'd0);
    tick();
    @(negedge clk);
    check("t5_next_addr", imem_addr, 32'h0000_0300);

    // T6: stall and redirect together in HOLD
    lat_fixed = 0;
    wait_ack(20);
    wait_ack(10);
    tick();
    stall = 1'b1;
    tick();
    @(negedge clk);
    check("t6_hold_req", 32'(imem_req), 32'd0);
    tick();
    br_taken  = 1'b1;
    br_target = 32'h0000_0400;
    start_stream(br_target);
    tick();
    br_taken = 1'b0;
    stall    = 1'b0;
    @(negedge clk);
    check("t6_valid", 32'(valid_if_id), 32'd0);
    check("t6_instr", instruction, NOP);
    check("t6_addr", imem_addr, 32'h0000_0400);
    check("t6_req", 32'(imem_req), 32'd1);

    // PC wrap at the top of the address space
    tick();
    br_taken  = 1'b1;
    br_target = 32'hFFFF_FFF9;
    start_stream(br_target);
    tick();
    br_taken = 1'b0;
    repeat (8) tick();

    // Randomized traffic with one asynchronous reset in the middle
    lat_fixed = -1;
    since = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (i == 1500) begin
        rst      = 1'b1;
        br_taken = 1'b0;
        stall    = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_req", 32'(imem_req), 32'd0);
        check("async_rst_valid", 32'(valid_if_id), 32'd0);
        check("async_rst_instr", instruction, NOP);
        check("async_rst_pc_if_id", pc_if_id, 32'd0);
      end else if (i == 1502) begin
        rst = 1'b0;
        start_stream(RESET_PC);
        since = 0;
      end else if (i > 1500 && i < 1502) begin
        rst = 1'b1;
      end else begin
        stall = ($urandom_range(0, 3) == 0);
        if (since >= 200 || $urandom_range(0, 15) == 0) begin
          br_taken = 1'b1;
          if ($urandom_range(0, 3) == 0)
            br_target = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
          else
            br_target = $urandom;
          start_stream(br_target);
          since = 0;
        end else begin
          br_taken = 1'b0;
          since++;
        end
      end
    end
    tick();
    br_taken = 1'b0;
    stall    = 1'b0;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
